// File: rtl/fifo_rtl_pkg.sv
// Shared FIFO definitions: pointer-width helper and default geometry.
package fifo_rtl_pkg;

  localparam int FIFO_DATA_W_DEF = 8;
  localparam int FIFO_DEPTH_DEF  = 16;

  // One extra bit above the address width distinguishes full from empty.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W register array: one synchronous write port, one asynchronous read port.
module fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // NOTE: storage has no reset; pointers and flags alone define which entries are live.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/param_sync_fifo.sv
// Parametrised single-clock FIFO with threshold flags, occupancy count and sticky errors.
// Define PARAM_SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is registered reads.
module param_sync_fifo
  import fifo_rtl_pkg::*;
#(
  parameter int DATA_W    = FIFO_DATA_W_DEF,
  parameter int DEPTH     = FIFO_DEPTH_DEF,
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [DATA_W-1:0]       wr_data,
  input  logic                    rd_en,
  output logic [DATA_W-1:0]       rd_data,
  output logic                    rd_valid,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [ptr_w(DEPTH)-1:0] count,
  output logic                    overflow,
  output logic                    underflow,
  input  logic                    clr_err
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("param_sync_fifo: DEPTH must be a power of two >= 2");
  end
  if (AFULL_TH > DEPTH) begin : g_bad_afull
    $error("param_sync_fifo: AFULL_TH must not exceed DEPTH");
  end

  logic [PW-1:0]     r_wptr, r_rptr, r_count;
  logic              r_full, r_empty, r_afull, r_aempty, r_ovf, r_unf;
  logic              w_wr_acc, w_rd_acc;
  logic [PW-1:0]     w_wptr_nxt, w_rptr_nxt, w_count_nxt;
  logic [DATA_W-1:0] w_head;

  // Acceptance uses the registered flags, so a full FIFO still frees a slot on a read but refuses the write.
  assign w_wr_acc    = wr_en & ~r_full;
  assign w_rd_acc    = rd_en & ~r_empty;
  assign w_wptr_nxt  = r_wptr + PW'(w_wr_acc);
  assign w_rptr_nxt  = r_rptr + PW'(w_rd_acc);
  assign w_count_nxt = w_wptr_nxt - w_rptr_nxt;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_afull  <= 1'b0;
      r_aempty <= 1'b1;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      r_wptr   <= w_wptr_nxt;
      r_rptr   <= w_rptr_nxt;
      r_count  <= w_count_nxt;
      r_full   <= (w_count_nxt == PW'(DEPTH));
      r_empty  <= (w_count_nxt == '0);
      r_afull  <= (int'(w_count_nxt) >= AFULL_TH);
      r_aempty <= (int'(w_count_nxt) <= AEMPTY_TH);
      r_ovf    <= (wr_en & r_full)  | (r_ovf & ~clr_err);
      r_unf    <= (rd_en & r_empty) | (r_unf & ~clr_err);
    end
  end

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_wr_acc),
    .i_waddr (r_wptr[AW-1:0]),
    .i_wdata (wr_data),
    .i_raddr (r_rptr[AW-1:0]),
    .o_rdata (w_head)
  );

`ifdef PARAM_SYNC_FIFO_FWFT_EN
  assign rd_data  = r_empty ? '0 : w_head;
  assign rd_valid = ~r_empty;
`else
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_acc;
      if (w_rd_acc) r_rd_data <= w_head;
    end
  end

  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
`endif

  assign count        = r_count;
  assign full         = r_full;
  assign empty        = r_empty;
  assign almost_full  = r_afull;
  assign almost_empty = r_aempty;
  assign overflow     = r_ovf;
  assign underflow    = r_unf;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed bench for param_sync_fifo (DATA_W=8, DEPTH=16, default thresholds 14 / 2).
module tb_param_sync_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_en = 1'b0;
  logic          clr_err = 1'b0;
  logic [DW-1:0] rd_data;
  logic          rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0]    count;
  logic [10:0]   obs_flags;

  int n_cmp = 0;
  int n_bad = 0;

  param_sync_fifo #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow),
    .clr_err      (clr_err)
  );

  always #5 clk = ~clk;

  assign obs_flags = {count, full, empty, almost_full, almost_empty, overflow, underflow};

  // Expected {count, full, empty, almost_full, almost_empty, overflow, underflow} for an occupancy.
  function automatic logic [10:0] exp_flags(input int occ, input bit ovf, input bit unf);
    logic [4:0] c;
    c = 5'(occ);
    return {c, occ == DEPTH, occ == 0, occ >= DEPTH - 2, occ <= 2, ovf, unf};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_flags(input string tag, input int occ, input bit ovf, input bit unf);
    n_cmp++;
    if (obs_flags !== exp_flags(occ, ovf, unf)) begin
      n_bad++;
      $display("FAIL %s flags got %b want %b", tag, obs_flags, exp_flags(occ, ovf, unf));
    end
  endtask

  // Pops one word and compares it against the expected head value in the current read mode.
  task automatic do_read(input logic [DW-1:0] exp, input string tag);
`ifdef PARAM_SYNC_FIFO_FWFT_EN
    n_cmp++;
    if ({rd_valid, rd_data} !== {1'b1, exp}) begin
      n_bad++;
      $display("FAIL %s got v=%b d=%h want v=1 d=%h", tag, rd_valid, rd_data, exp);
    end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
`else
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    n_cmp++;
    if ({rd_valid, rd_data} !== {1'b1, exp}) begin
      n_bad++;
      $display("FAIL %s got v=%b d=%h want v=1 d=%h", tag, rd_valid, rd_data, exp);
    end
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk_flags("reset", 0, 1'b0, 1'b0);
    n_cmp++;
    if ({rd_valid, rd_data} !== 9'h000) begin
      n_bad++;
      $display("FAIL reset_rd got v=%b d=%h want v=0 d=00", rd_valid, rd_data);
    end
  endtask

  task automatic test_fill_drain();
    logic [DW-1:0] exp_hold;
    for (int i = 0; i < DEPTH; i++) begin
      wr_en   = 1'b1;
      wr_data = DW'(i);
      tick();
      chk_flags("fill", i + 1, 1'b0, 1'b0);
    end
    wr_en = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      do_read(DW'(i), "drain_data");
      chk_flags("drain", DEPTH - 1 - i, 1'b0, 1'b0);
    end
    tick();
`ifdef PARAM_SYNC_FIFO_FWFT_EN
    exp_hold = 8'h00;
`else
    exp_hold = 8'h0F;
`endif
    n_cmp++;
    if ({rd_valid, rd_data} !== {1'b0, exp_hold}) begin
      n_bad++;
      $display("FAIL idle_hold got v=%b d=%h want v=0 d=%h", rd_valid, rd_data, exp_hold);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < DEPTH; i++) begin
      wr_en   = 1'b1;
      wr_data = DW'(8'h10 + i);
      tick();
    end
    wr_data = 8'hEE;
    rd_en   = 1'b1;
`ifdef PARAM_SYNC_FIFO_FWFT_EN
    n_cmp++;
    if ({rd_valid, rd_data} !== 9'h110) begin
      n_bad++;
      $display("FAIL ovf_pop got v=%b d=%h want v=1 d=10", rd_valid, rd_data);
    end
    tick();
`else
    tick();
    n_cmp++;
    if ({rd_valid, rd_data} !== 9'h110) begin
      n_bad++;
      $display("FAIL ovf_pop got v=%b d=%h want v=1 d=10", rd_valid, rd_data);
    end
`endif
    wr_en = 1'b0;
    rd_en = 1'b0;
    chk_flags("ovf_set", DEPTH - 1, 1'b1, 1'b0);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk_flags("ovf_clr", DEPTH - 1, 1'b0, 1'b0);
    wr_en   = 1'b1;
    wr_data = 8'h20;
    tick();
    chk_flags("refill", DEPTH, 1'b0, 1'b0);
    wr_data = 8'hFF;
    tick();
    chk_flags("ovf_again", DEPTH, 1'b1, 1'b0);
    clr_err = 1'b1;
    tick();
    chk_flags("ovf_clr_vs_set", DEPTH, 1'b1, 1'b0);
    wr_en = 1'b0;
    tick();
    clr_err = 1'b0;
    chk_flags("ovf_clr2", DEPTH, 1'b0, 1'b0);
    for (int i = 1; i <= DEPTH; i++) begin
      do_read(DW'(8'h10 + i), "ovf_drain");
    end
    chk_flags("ovf_empty", 0, 1'b0, 1'b0);
  endtask

  task automatic test_underflow();
    logic [8:0] exp_rd;
    wr_en   = 1'b1;
    rd_en   = 1'b1;
    wr_data = 8'hA5;
    tick();
    wr_en = 1'b0;
    rd_en = 1'b0;
    chk_flags("unf_set", 1, 1'b0, 1'b1);
`ifdef PARAM_SYNC_FIFO_FWFT_EN
    exp_rd = 9'h1A5;
`else
    exp_rd = {1'b0, 8'h20};
`endif
    n_cmp++;
    if ({rd_valid, rd_data} !== exp_rd) begin
      n_bad++;
      $display("FAIL unf_rd got %h want %h", {rd_valid, rd_data}, exp_rd);
    end
    do_read(8'hA5, "unf_data");
    chk_flags("unf_sticky", 0, 1'b0, 1'b1);
    rd_en   = 1'b1;
    clr_err = 1'b1;
    tick();
    rd_en = 1'b0;
    chk_flags("unf_clr_vs_set", 0, 1'b0, 1'b1);
    tick();
    clr_err = 1'b0;
    chk_flags("unf_clr", 0, 1'b0, 1'b0);
  endtask

  task automatic test_wrap();
    logic [DW-1:0] q[$];
    logic [DW-1:0] exp;
    int  wn  = 0;
    int  rn  = 0;
    int  cyc = 0;
    bit  do_wr, do_rd;
    int  occ;
    while ((wn < 40 || rn < 40) && cyc < 400) begin
      occ   = q.size();
      do_wr = (wn < 40) && (occ < 15) && (($urandom_range(0, 2) != 0) || occ <= 1);
      do_rd = (occ >= 1) && (($urandom_range(0, 2) != 0) || wn == 40) &&
              !(occ == 1 && !do_wr && wn < 40);
`ifdef PARAM_SYNC_FIFO_FWFT_EN
      if (do_rd) begin
        n_cmp++;
        if ({rd_valid, rd_data} !== {1'b1, q[0]}) begin
          n_bad++;
          $display("FAIL wrap_data got v=%b d=%h want v=1 d=%h", rd_valid, rd_data, q[0]);
        end
      end
`endif
      wr_en   = do_wr;
      wr_data = DW'(wn);
      rd_en   = do_rd;
      tick();
      exp = '0;
      if (do_rd) begin
        exp = q.pop_front();
        rn++;
      end
      if (do_wr) begin
        q.push_back(DW'(wn));
        wn++;
      end
`ifndef PARAM_SYNC_FIFO_FWFT_EN
      n_cmp++;
      if (rd_valid !== do_rd || (do_rd && rd_data !== exp)) begin
        n_bad++;
        $display("FAIL wrap_data got v=%b d=%h want v=%b d=%h", rd_valid, rd_data, do_rd, exp);
      end
`endif
      chk_flags("wrap_flags", q.size(), 1'b0, 1'b0);
      cyc++;
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
    n_cmp++;
    if (wn != 40 || rn != 40) begin
      n_bad++;
      $display("FAIL wrap_timeout got w=%0d r=%0d want w=40 r=40", wn, rn);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      wr_en   = 1'b1;
      wr_data = DW'(8'h55 + i);
      tick();
    end
    wr_en = 1'b0;
    rst   = 1'b1;
    tick();
    rst = 1'b0;
    chk_flags("mid_reset", 0, 1'b0, 1'b0);
    n_cmp++;
    if (rd_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_reset_valid got %b want 0", rd_valid);
    end
    wr_en   = 1'b1;
    wr_data = 8'h77;
    tick();
    wr_en = 1'b0;
    do_read(8'h77, "mid_reset_data");
    chk_flags("mid_reset_after", 0, 1'b0, 1'b0);
  endtask

`ifdef PARAM_SYNC_FIFO_FWFT_EN
  task automatic test_fwft();
    wr_en   = 1'b1;
    wr_data = 8'h3C;
    tick();
    wr_en = 1'b0;
    n_cmp++;
    if ({rd_valid, rd_data} !== 9'h13C) begin
      n_bad++;
      $display("FAIL fwft_show got v=%b d=%h want v=1 d=3c", rd_valid, rd_data);
    end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk_flags("fwft_pop", 0, 1'b0, 1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow();
    test_wrap();
    test_reset_mid();
`ifdef PARAM_SYNC_FIFO_FWFT_EN
    test_fwft();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
